// File: rtl/mandelbrot_render_scheduler.sv
// rtl/mandelbrot_render_scheduler.sv - raster-order pixel dispatch to N point engines with in-order result stream
// Optional MANDEL_COORD_TAG_EN adds out_x/out_y pixel coordinate tags on the result stream.
module mandelbrot_render_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int COORD_W     = 12,
  parameter int ITER_W      = 32
) (
  input  logic                           CLK,
  input  logic                           SYS_RESET_N,
  input  logic                           start_render,
  input  logic                           abort,
  input  logic [COORD_W-1:0]             x_size,
  input  logic [COORD_W-1:0]             y_size,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [NUM_ENGINES*COORD_W-1:0] eng_x,
  output logic [NUM_ENGINES*COORD_W-1:0] eng_y,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0]  eng_iter,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ITER_W-1:0]              out_data,
  output logic                           out_last,
  output logic                           busy,
`ifdef MANDEL_COORD_TAG_EN
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
`endif
  output logic                           frame_done
);

  localparam int PW  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int CW2 = 2 * COORD_W;
  localparam logic [PW-1:0] PTR_MAX = PW'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} state_t;

  state_t                   state_q, state_d;
  logic [COORD_W-1:0]       xs_q, xs_d, x_q, x_d, y_q, y_d;
  logic [CW2-1:0]           total_q, total_d, iss_q, iss_d, ocnt_q, ocnt_d;
  logic [PW-1:0]            dptr_q, dptr_d, optr_q, optr_d;
  logic [NUM_ENGINES-1:0]   busy_q, busy_d, full_q, full_d, eng_start_q, eng_start_d;
  logic [ITER_W-1:0]        slot_data_q [NUM_ENGINES];
  logic [ITER_W-1:0]        slot_data_d [NUM_ENGINES];
  logic [COORD_W-1:0]       eng_x_q [NUM_ENGINES];
  logic [COORD_W-1:0]       eng_x_d [NUM_ENGINES];
  logic [COORD_W-1:0]       eng_y_q [NUM_ENGINES];
  logic [COORD_W-1:0]       eng_y_d [NUM_ENGINES];
  logic                     frame_done_q, frame_done_d;
  logic                     hs, dispatch;
`ifdef MANDEL_COORD_TAG_EN
  logic [COORD_W-1:0]       slot_x_q [NUM_ENGINES];
  logic [COORD_W-1:0]       slot_x_d [NUM_ENGINES];
  logic [COORD_W-1:0]       slot_y_q [NUM_ENGINES];
  logic [COORD_W-1:0]       slot_y_d [NUM_ENGINES];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign out_valid  = (state_q == S_RUN) && full_q[optr_q];
  assign out_data   = slot_data_q[optr_q];
  assign out_last   = (state_q == S_RUN) && ((ocnt_q + CW2'(1)) == total_q);
  assign hs         = out_valid && out_ready;
  assign dispatch   = (state_q == S_RUN) && !abort && !busy_q[dptr_q] && (iss_q < total_q);
  assign busy       = (state_q != S_IDLE);
  assign eng_start  = eng_start_q;
  assign frame_done = frame_done_q;
`ifdef MANDEL_COORD_TAG_EN
  assign out_x = slot_x_q[optr_q];
  assign out_y = slot_y_q[optr_q];
`endif

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_pack
    assign eng_x[g*COORD_W +: COORD_W] = eng_x_q[g];
    assign eng_y[g*COORD_W +: COORD_W] = eng_y_q[g];
  end

  always_comb begin
    state_d      = state_q;
    xs_d         = xs_q;
    x_d          = x_q;
    y_d          = y_q;
    total_d      = total_q;
    iss_d        = iss_q;
    ocnt_d       = ocnt_q;
    dptr_d       = dptr_q;
    optr_d       = optr_q;
    busy_d       = busy_q;
    full_d       = full_q;
    slot_data_d  = slot_data_q;
    eng_x_d      = eng_x_q;
    eng_y_d      = eng_y_q;
    eng_start_d  = '0;
    frame_done_d = 1'b0;
`ifdef MANDEL_COORD_TAG_EN
    slot_x_d     = slot_x_q;
    slot_y_d     = slot_y_q;
`endif
    case (state_q)
      S_IDLE: begin
        // frame_done_q high means the previous frame ended this cycle; its start is ignored
        if (start_render && !frame_done_q && (x_size != '0) && (y_size != '0)) begin
          xs_d    = x_size;
          total_d = CW2'(x_size) * CW2'(y_size);
          x_d     = '0;
          y_d     = '0;
          iss_d   = '0;
          ocnt_d  = '0;
          dptr_d  = '0;
          optr_d  = '0;
          busy_d  = '0;
          full_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NUM_ENGINES; k++) begin
          if (eng_done[k] && busy_q[k] && !full_q[k]) begin
            full_d[k]      = 1'b1;
            slot_data_d[k] = eng_iter[k*ITER_W +: ITER_W];
`ifdef MANDEL_COORD_TAG_EN
            slot_x_d[k]    = eng_x_q[k];
            slot_y_d[k]    = eng_y_q[k];
`endif
          end
        end
        if (hs) begin
          full_d[optr_q] = 1'b0;
          busy_d[optr_q] = 1'b0;
          optr_d         = ptr_inc(optr_q);
          ocnt_d         = ocnt_q + CW2'(1);
        end
        if (hs && out_last) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else if (abort) begin
          // Captured and just-finished results are dropped; only engines still computing stay busy
          state_d = S_ABORT;
          full_d  = '0;
          busy_d  = busy_d & ~full_q & ~eng_done;
        end
        if (dispatch) begin
          eng_start_d[dptr_q] = 1'b1;
          busy_d[dptr_q]      = 1'b1;
          eng_x_d[dptr_q]     = x_q;
          eng_y_d[dptr_q]     = y_q;
          iss_d               = iss_q + CW2'(1);
          dptr_d              = ptr_inc(dptr_q);
          if (x_q == xs_q - COORD_W'(1)) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      S_ABORT: begin
        busy_d = busy_q & ~eng_done;
        if (busy_q == '0) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q      <= S_IDLE;
      xs_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      total_q      <= '0;
      iss_q        <= '0;
      ocnt_q       <= '0;
      dptr_q       <= '0;
      optr_q       <= '0;
      busy_q       <= '0;
      full_q       <= '0;
      eng_start_q  <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < NUM_ENGINES; k++) begin
        slot_data_q[k] <= '0;
        eng_x_q[k]     <= '0;
        eng_y_q[k]     <= '0;
`ifdef MANDEL_COORD_TAG_EN
        slot_x_q[k]    <= '0;
        slot_y_q[k]    <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      xs_q         <= xs_d;
      x_q          <= x_d;
      y_q          <= y_d;
      total_q      <= total_d;
      iss_q        <= iss_d;
      ocnt_q       <= ocnt_d;
      dptr_q       <= dptr_d;
      optr_q       <= optr_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
      eng_start_q  <= eng_start_d;
      frame_done_q <= frame_done_d;
      slot_data_q  <= slot_data_d;
      eng_x_q      <= eng_x_d;
      eng_y_q      <= eng_y_d;
`ifdef MANDEL_COORD_TAG_EN
      slot_x_q     <= slot_x_d;
      slot_y_q     <= slot_y_d;
`endif
    end
  end

endmodule

// File: tb/tb_mandelbrot_render_scheduler.sv
// tb/tb_mandelbrot_render_scheduler.sv - directed table-driven bench for mandelbrot_render_scheduler
module tb_mandelbrot_render_scheduler;
  localparam int N  = 4;
  localparam int CW = 12;
  localparam int IW = 32;

  logic              CLK = 1'b0;
  logic              SYS_RESET_N;
  logic              start_render, abort, out_ready;
  logic [CW-1:0]     x_size, y_size;
  logic [N-1:0]      eng_start;
  logic [N*CW-1:0]   eng_x, eng_y;
  logic [N-1:0]      eng_done = '0;
  logic [N*IW-1:0]   eng_iter = '0;
  logic              out_valid, out_last, busy, frame_done;
  logic [IW-1:0]     out_data;
`ifdef MANDEL_COORD_TAG_EN
  logic [CW-1:0]     out_x, out_y;
`endif

  always #5 CLK = ~CLK;

  mandelbrot_render_scheduler #(.NUM_ENGINES(N), .COORD_W(CW), .ITER_W(IW)) dut (
    .CLK(CLK), .SYS_RESET_N(SYS_RESET_N), .start_render(start_render), .abort(abort),
    .x_size(x_size), .y_size(y_size), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_iter(eng_iter), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
`ifdef MANDEL_COORD_TAG_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] iter_of(input int x, input int y);
    return IW'(y * 4096 + x * 3 + 5);
  endfunction

  // Point-engine model: fixed latency per engine, result derived from the pixel coordinate
  int lat [N];
  int cnt [N] = '{default: 0};
  int px [N];
  int py [N];
  int disp_total = 0;

  always @(negedge CLK) begin
    eng_done = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          eng_done[k] = 1'b1;
          eng_iter[k*IW +: IW] = iter_of(px[k], py[k]);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (eng_start[k]) begin
        cnt[k] = lat[k];
        px[k]  = int'(eng_x[k*CW +: CW]);
        py[k]  = int'(eng_y[k*CW +: CW]);
        disp_total++;
      end
    end
  end

  // Result collector: raster-order scoreboard
  int w_cur = 1;
  int exp_total = 0;
  int got = 0;
  int pix_total = 0;
  int last_total = 0;
  bit abort_mode = 1'b0;
  bit last_hs_prev = 1'b0;

  always @(negedge CLK) begin
    if (SYS_RESET_N) begin
      if (frame_done) begin
        if (!abort_mode) chk("fd_after_last", longint'(last_hs_prev), 1);
        got = 0;
      end
      if (abort_mode && out_valid) chk("valid_in_abort", 1, 0);
      last_hs_prev = 1'b0;
      if (out_valid && out_ready) begin
        chk("data", out_data, iter_of(got % w_cur, got / w_cur));
        chk("last", out_last, longint'(got == exp_total - 1));
`ifdef MANDEL_COORD_TAG_EN
        chk("tag_x", out_x, got % w_cur);
        chk("tag_y", out_y, got / w_cur);
`endif
        if (out_last) last_total++;
        last_hs_prev = out_last;
        got++;
        pix_total++;
      end
    end
  end

  task automatic start_frame(input int w, input int h);
    @(posedge CLK); #1;
    w_cur = (w == 0) ? 1 : w;
    exp_total = w * h;
    x_size = CW'(w);
    y_size = CW'(h);
    start_render = 1'b1;
    @(posedge CLK); #1;
    start_render = 1'b0;
  endtask

  task automatic wait_fd(input int budget, input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (!frame_done && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!frame_done) chk(name, 0, 1);
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  typedef struct {
    int w; int h;
    int l0; int l1; int l2; int l3;
    int disp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p0, d0, l0, esum;
    logic [IW-1:0] held;
    bit have;

    vecs[0] = '{w: 4, h: 2, l0: 3, l1: 3, l2: 3, l3: 3, disp: 8};
    vecs[1] = '{w: 4, h: 1, l0: 9, l1: 7, l2: 5, l3: 3, disp: 4};
    vecs[2] = '{w: 3, h: 1, l0: 3, l1: 3, l2: 3, l3: 3, disp: 3};
    vecs[3] = '{w: 5, h: 3, l0: 2, l1: 4, l2: 1, l3: 3, disp: 15};
    vecs[4] = '{w: 1, h: 1, l0: 1, l1: 1, l2: 1, l3: 1, disp: 1};

    SYS_RESET_N = 1'b0; start_render = 1'b0; abort = 1'b0; out_ready = 1'b1;
    x_size = '0; y_size = '0;
    set_lat(3, 3, 3, 3);
    repeat (3) @(posedge CLK);
    #1 SYS_RESET_N = 1'b1;

    @(negedge CLK);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_eng_y", eng_y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    for (int i = 0; i < 5; i++) begin
      set_lat(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3);
      p0 = pix_total; d0 = disp_total; l0 = last_total;
      start_frame(vecs[i].w, vecs[i].h);
      wait_fd(600, "frame_timeout");
      chk("pixels", pix_total - p0, vecs[i].w * vecs[i].h);
      chk("dispatches", disp_total - d0, vecs[i].disp);
      chk("last_count", last_total - l0, 1);
      @(negedge CLK);
      chk("busy_after", busy, 0);
      chk("fd_pulse_width", frame_done, 0);
    end

    // Backpressure: 20 stalled cycles, all four slots fill, nothing is redispatched
    set_lat(3, 3, 3, 3);
    out_ready = 1'b0;
    p0 = pix_total; d0 = disp_total;
    have = 1'b0; held = '0;
    start_frame(4, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        if (!have) begin
          held = out_data;
          have = 1'b1;
        end else begin
          chk("stall_data", out_data, held);
        end
      end
    end
    chk("stall_valid", out_valid, 1);
    chk("stall_first", held, iter_of(0, 0));
    chk("stall_dispatch", disp_total - d0, 4);
    @(posedge CLK); #1 out_ready = 1'b1;
    wait_fd(600, "stall_timeout");
    chk("stall_pixels", pix_total - p0, 8);
    chk("stall_dispatch_total", disp_total - d0, 8);

    // start_render coinciding with frame_done is ignored
    start_frame(2, 1);
    wait_fd(200, "coinc_timeout");
    d0 = disp_total;
    x_size = CW'(2); y_size = CW'(1); start_render = 1'b1;
    @(posedge CLK); #1 start_render = 1'b0;
    repeat (5) @(negedge CLK);
    chk("coinc_busy", busy, 0);
    chk("coinc_dispatch", disp_total - d0, 0);

    // Abort with three engines in flight
    set_lat(20, 23, 27, 1);
    p0 = pix_total; d0 = disp_total;
    start_frame(3, 1);
    repeat (5) @(negedge CLK);
    @(posedge CLK); #1 abort = 1'b1; abort_mode = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    chk("abort_busy_during", busy, 1);
    wait_fd(200, "abort_timeout");
    esum = cnt[0] + cnt[1] + cnt[2] + cnt[3];
    chk("abort_engines_drained", esum, 0);
    chk("abort_pixels", pix_total - p0, 0);
    chk("abort_dispatch", disp_total - d0, 3);
    @(negedge CLK);
    chk("abort_busy_after", busy, 0);
    abort_mode = 1'b0;
    set_lat(3, 3, 3, 3);
    p0 = pix_total;
    start_frame(2, 2);
    wait_fd(300, "post_abort_timeout");
    chk("post_abort_pixels", pix_total - p0, 4);

    // Zero-sized frames are ignored
    d0 = disp_total;
    start_frame(0, 3);
    repeat (5) @(negedge CLK);
    chk("zero_x_busy", busy, 0);
    start_frame(3, 0);
    repeat (5) @(negedge CLK);
    chk("zero_y_busy", busy, 0);
    chk("zero_dispatch", disp_total - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
